// File: rtl/simd_issue_unit_if.sv
// simd_issue_unit_if
//   Instruction issue handshake between an instruction source and the
//   simd_issue_unit.
//   Signals:
//     instr_valid   source -> unit  instruction offered
//     instr_ready   unit -> source  unit can accept an instruction
//     instr_opcode  source -> unit  00 ADD, 01 MUL, 10/11 illegal
//     instr_rd      source -> unit  destination register
//     instr_rs1     source -> unit  source A register
//     instr_rs2     source -> unit  source B register
//   Modports: master (instruction source), slave (simd_issue_unit).
interface simd_issue_unit_if #(
  parameter int ADDR_W = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        instr_opcode;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;

  modport master (
    output instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
    output instr_ready
  );
endinterface

// File: rtl/simd_issue_unit.sv
// simd_issue_unit
//   Issue/writeback stage in front of simd_core. Accepts one vector
//   instruction at a time, reads both operands from an internal vector
//   register file, presents them to the core, waits the core latency and
//   writes the core result back to the destination register. A host port
//   can preload and inspect the register file at any time.
//   Ports:
//     clk, reset      clock; synchronous active-high reset
//     instr           instruction handshake (slave side)
//     rf_wr_en/addr/data   host register write
//     rf_rd_addr/rf_rd_data host register read, 1-cycle latency
//     core_opcode/src_a/src_b registered operands to simd_core
//     core_result     result from simd_core
//     busy            instruction in flight
//     done            1-cycle pulse, writeback this cycle
//     err             1-cycle pulse, illegal opcode dropped
module simd_issue_unit #(
  parameter int NUM_REGS     = 8,
  parameter int ADDR_W       = 3,
  parameter int LANES        = 4,
  parameter int LANE_W       = 32,
  parameter int SIMD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  simd_issue_unit_if.slave         instr,
  input  logic                     rf_wr_en,
  input  logic [ADDR_W-1:0]        rf_wr_addr,
  input  logic [LANES*LANE_W-1:0]  rf_wr_data,
  input  logic [ADDR_W-1:0]        rf_rd_addr,
  output logic [LANES*LANE_W-1:0]  rf_rd_data,
  output logic [1:0]               core_opcode,
  output logic [LANES*LANE_W-1:0]  core_src_a,
  output logic [LANES*LANE_W-1:0]  core_src_b,
  input  logic [LANES*LANE_W-1:0]  core_result,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int VW    = LANES * LANE_W;
  localparam int LAT_W = (SIMD_LATENCY < 2) ? 1 : $clog2(SIMD_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [LAT_W-1:0]  lat_cnt_r;
  logic [ADDR_W-1:0] rd_r;
  logic              err_r;
  logic [VW-1:0]     rf_r [NUM_REGS];

  logic              ready_s;
  logic              accept_s;
  logic              legal_s;
  logic              wb_s;
  logic              host_we_s;

  assign instr.instr_ready = ready_s;

  // Next-state decode and status outputs; status is forced low while reset is held.
  always_comb begin
    state_next_s = state_r;
    ready_s      = 1'b0;
    accept_s     = 1'b0;
    wb_s         = 1'b0;
    legal_s      = ~instr.instr_opcode[1];
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    case (state_r)
      IDLE: begin
        ready_s  = ~reset;
        accept_s = instr.instr_valid & ready_s;
        // Illegal opcodes are consumed without leaving IDLE.
        if (accept_s && legal_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        if (lat_cnt_r == LAT_W'(1)) begin
          state_next_s = WB;
        end else begin
          state_next_s = EXEC;
        end
      end
      WB: begin
        wb_s         = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    busy = (state_r != IDLE) & ~reset;
    done = wb_s & ~reset;
    err  = err_r & ~reset;

    // Writeback owns the port on a same-address collision.
    if (wb_s && (rf_wr_addr == rd_r)) begin
      host_we_s = 1'b0;
    end else begin
      host_we_s = rf_wr_en;
    end
  end

  // FSM state, latency counter, destination latch and core operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      lat_cnt_r   <= '0;
      rd_r        <= '0;
      err_r       <= 1'b0;
      core_opcode <= 2'b00;
      core_src_a  <= '0;
      core_src_b  <= '0;
    end else begin
      state_r <= state_next_s;
      err_r   <= accept_s & ~legal_s;
      if (accept_s && legal_s) begin
        // Operands come from the pre-edge file contents (read-before-write).
        core_opcode <= instr.instr_opcode;
        core_src_a  <= rf_r[instr.instr_rs1];
        core_src_b  <= rf_r[instr.instr_rs2];
        rd_r        <= instr.instr_rd;
        lat_cnt_r   <= LAT_W'(SIMD_LATENCY);
      end else if (state_r == EXEC) begin
        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
      end else begin
        lat_cnt_r <= lat_cnt_r;
      end
    end
  end

  // Register file storage, host write, writeback and registered host read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_r[i] <= '0;
      end
      rf_rd_data <= '0;
    end else begin
      rf_rd_data <= rf_r[rf_rd_addr];
      if (host_we_s) begin
        rf_r[rf_wr_addr] <= rf_wr_data;
      end
      if (wb_s) begin
        rf_r[rd_r] <= core_result;
      end
    end
  end

endmodule
